clk_enable_divider: RTL and testbench

//  Multi-channel, runtime-programmable clock divider for the display pipeline.

---
 rtl/clkdiv_pkg.sv | 20 ++
 rtl/clkdiv_channel.sv | 83 ++++++++
 rtl/clk_enable_divider.sv | 64 ++++++
 tb/tb_clk_enable_divider.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared defaults, channel-index width helper and channel state type for the
// clock-enable divider.
package clkdiv_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int CNT_W_DEF   = 32;
  localparam int DEF_DIV_DEF = 1;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_IDX_W = ch_idx_w(NUM_CH_DEF);

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor, pending flag and the
// registered tick / square-wave outputs.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             tick_o,
  output logic             sq_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             apply;
  ch_state_e        state;

  assign state = (en_i && (active_q != '0)) ? CH_RUN : CH_IDLE;

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    sq_d     = sq_q;
    apply    = 1'b0;
    if (sync_i || (state == CH_IDLE)) begin
      count_d = '0;
      sq_d    = 1'b0;
      apply   = pend_q;
    end else if (count_q >= active_q - CNT_W'(1)) begin
      // >= rather than == lets a counter left above a shrunk divisor recover
      count_d = '0;
      tick_d  = 1'b1;
      sq_d    = ~sq_q;
      apply   = pend_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    if (apply) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
    // A write is only accepted while nothing is pending, so it never races an apply
    if (wr_i) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      active_q <= CNT_W'(DEF_DIV);
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i) shadow_q <= wr_div_i;
  end

  assign pend_o = pend_q;
  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/clk_enable_divider.sv
// Multi-channel programmable clock-enable divider (tick strobe + 50% square wave).
// Define CLKDIV_SYNC_EN to add the global phase-realign input 'sync'.
module clk_enable_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             sq
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic                          sync
`endif
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  logic              sync_w;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range channels read as ready so the write is consumed and dropped
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == IDX_W'(i)) cfg_ready = ~pend[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = cfg_valid & cfg_ready & (cfg_ch == IDX_W'(g));

    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (ch_en[g]),
      .sync_i   (sync_w),
      .wr_i     (wr[g]),
      .wr_div_i (cfg_div),
      .pend_o   (pend[g]),
      .tick_o   (tick[g]),
      .sq_o     (sq[g])
    );
  end

endmodule

// File: tb/tb_clk_enable_divider.sv
// Directed testbench for clk_enable_divider (main 4-channel instance plus a
// 3-channel instance used to reach an out-of-range cfg_ch).
module tb_clk_enable_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [3:0]  tick;
  logic [3:0]  sq;

  logic [2:0]  ch_en3 = 3'b111;
  logic        cfg_valid3;
  logic        cfg_ready3;
  logic [1:0]  cfg_ch3;
  logic [7:0]  cfg_div3;
  logic [2:0]  tick3;
  logic [2:0]  sq3;

`ifdef CLKDIV_SYNC_EN
  logic        sync = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_enable_divider #(.NUM_CH(4), .CNT_W(32), .DEF_DIV(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq        (sq)
`ifdef CLKDIV_SYNC_EN
    ,
    .sync      (sync)
`endif
  );

  clk_enable_divider #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(1)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en3),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_div   (cfg_div3),
    .tick      (tick3),
    .sq        (sq3)
`ifdef CLKDIV_SYNC_EN
    ,
    .sync      (sync)
`endif
  );

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = 4'b0000; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 32'd0;
    cfg_valid3 = 1'b0; cfg_ch3 = 2'd0; cfg_div3 = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (tick !== 4'b0000) begin failures++; $display("FAIL reset_tick got=%b exp=0000", tick); end
    checks++; if (sq !== 4'b0000) begin failures++; $display("FAIL reset_sq got=%b exp=0000", sq); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    checks++; if ({tick3, sq3} !== 6'b0) begin failures++; $display("FAIL reset_dut3 got=%b exp=000000", {tick3, sq3}); end
  endtask

  task automatic test_default_div();
    logic s;
    ch_en = 4'b0001;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s = (k % 2 == 0);
      checks++; if (tick !== 4'b0001) begin failures++; $display("FAIL div1_tick k=%0d got=%b exp=0001", k, tick); end
      checks++; if (sq !== {3'b000, s}) begin failures++; $display("FAIL div1_sq k=%0d got=%b exp=%b", k, sq, {3'b000, s}); end
    end
    checks++; if (tick3 !== 3'b111) begin failures++; $display("FAIL dut3_tick got=%b exp=111", tick3); end
  endtask

  task automatic test_idle_write();
    logic t, s;
    ch_en = 4'b0000;
    cfg_write(2'd2, 32'd5);
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL idle_ready_pend got=%b exp=0", cfg_ready); end
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_ready_applied got=%b exp=1", cfg_ready); end
    checks++; if ({tick, sq} !== 8'h00) begin failures++; $display("FAIL idle_outputs got=%b exp=00000000", {tick, sq}); end
    ch_en = 4'b0100;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      t = ((k + 1) % 5 == 0);
      s = (((k + 1) / 5) % 2 == 1);
      checks++; if (tick !== {1'b0, t, 2'b00}) begin failures++; $display("FAIL d5_tick k=%0d got=%b exp=%b", k, tick, {1'b0, t, 2'b00}); end
      checks++; if (sq !== {1'b0, s, 2'b00}) begin failures++; $display("FAIL d5_sq k=%0d got=%b exp=%b", k, sq, {1'b0, s, 2'b00}); end
    end
  endtask

  task automatic test_pending_hold();
    logic t, r;
    ch_en = 4'b0000;
    cfg_write(2'd1, 32'd4);
    @(negedge clk);
    ch_en = 4'b0010;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd2;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_pre got=%b exp=1", cfg_ready); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) cfg_valid = 1'b0;
      t = (k == 3) || (k >= 5 && (k % 2 == 1));
      r = (k >= 3);
      checks++; if (tick !== {2'b00, t, 1'b0}) begin failures++; $display("FAIL hold_tick k=%0d got=%b exp=%b", k, tick, {2'b00, t, 1'b0}); end
      checks++; if (cfg_ready !== r) begin failures++; $display("FAIL hold_ready k=%0d got=%b exp=%b", k, cfg_ready, r); end
    end
  endtask

  task automatic test_tc_write();
    logic t, r;
    ch_en = 4'b0000;
    cfg_write(2'd0, 32'd3);
    @(negedge clk);
    ch_en = 4'b0001;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      t = (k == 2) || (k == 5) || (k == 11) || (k == 17);
      r = !(k >= 2 && k < 5);
      checks++; if (tick !== {3'b000, t}) begin failures++; $display("FAIL tc_tick k=%0d got=%b exp=%b", k, tick, {3'b000, t}); end
      checks++; if (cfg_ready !== r) begin failures++; $display("FAIL tc_ready k=%0d got=%b exp=%b", k, cfg_ready, r); end
      if (k == 1) begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd6; end
      if (k == 2) cfg_valid = 1'b0;
    end
  endtask

  task automatic test_zero_and_oob();
    cfg_write(2'd0, 32'd0);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({tick, sq} !== 8'h00) begin failures++; $display("FAIL zero_idle k=%0d got=%b exp=00000000", k, {tick, sq}); end
    end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%b exp=1", cfg_ready); end
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd0;
    checks++; if (cfg_ready3 !== 1'b1) begin failures++; $display("FAIL oob_ready got=%b exp=1", cfg_ready3); end
    @(negedge clk);
    cfg_valid3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (tick3 !== 3'b111) begin failures++; $display("FAIL oob_tick k=%0d got=%b exp=111", k, tick3); end
    end
  endtask

  task automatic test_reset_mid();
    ch_en = 4'b0000;
    cfg_write(2'd3, 32'd7);
    @(negedge clk);
    ch_en = 4'b1000;
    repeat (8) @(negedge clk);
    checks++; if (sq !== 4'b1000) begin failures++; $display("FAIL rstmid_pre_sq got=%b exp=1000", sq); end
    cfg_write(2'd3, 32'd2);
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rstmid_pend got=%b exp=0", cfg_ready); end
    rst = 1'b1;
    #1;
    checks++; if ({tick, sq} !== 8'h00) begin failures++; $display("FAIL rstmid_out got=%b exp=00000000", {tick, sq}); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", cfg_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (tick !== 4'b1000) begin failures++; $display("FAIL rstmid_div1 k=%0d got=%b exp=1000", k, tick); end
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    logic t;
    ch_en = 4'b0000;
    cfg_write(2'd0, 32'd3);
    cfg_write(2'd1, 32'd3);
    @(negedge clk);
    ch_en = 4'b0001;
    @(negedge clk);
    ch_en = 4'b0011;
    repeat (2) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    checks++; if ({tick, sq} !== 8'h00) begin failures++; $display("FAIL sync_clear got=%b exp=00000000", {tick, sq}); end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      t = ((k + 1) % 3 == 0);
      checks++; if (tick !== {2'b00, t, t}) begin failures++; $display("FAIL sync_tick k=%0d got=%b exp=%b", k, tick, {2'b00, t, t}); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_div();
    test_idle_write();
    test_pending_hold();
    test_tc_write();
    test_zero_and_oob();
    test_reset_mid();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
